// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
//   Shared definitions for the push-button down counter.
//   - pressState_t : press-FSM state encoding (IDLE, ARMED, PRESSED)
//   - DEFAULT_DEBOUNCE_CYCLES : default stability window when DEBOUNCE_EN is defined
//   - BTN_DEC / BTN_LOAD : button slot indices used by the top-level generate loop
// -----------------------------------------------------------------------------
package btn_pkg;

   typedef enum logic [1:0] {
      PRESS_IDLE    = 2'd0,
      PRESS_ARMED   = 2'd1,
      PRESS_PRESSED = 2'd2
   } pressState_t;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

   localparam int NUM_BUTTONS = 2;
   localparam int BTN_DEC     = 0;
   localparam int BTN_LOAD    = 1;

endpackage : btn_pkg

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//   Turns one raw, asynchronous push-button into a single-cycle press strobe:
//   2-FF synchroniser -> optional debounce filter -> press FSM.
//   Build option: define DEBOUNCE_EN to insert the stability filter
//   (level accepted after DEBOUNCE_CYCLES identical synchronised samples).
//
// Ports
//   clk         in   1   system clock, rising edge
//   reset       in   1   asynchronous, active-low reset
//   btnRaw      in   1   raw button level, asynchronous to clk
//   pressStrobe out  1   high for one cycle per accepted press
// -----------------------------------------------------------------------------
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic btnRaw,
   output logic pressStrobe
);

   if (DEBOUNCE_CYCLES < 1) begin : gBadDebounce
      $error("btn_conditioner: DEBOUNCE_CYCLES must be at least 1");
   end

   // ---------------------------------------------------------------------
   // Synchroniser. syncValid tracks how many real samples have reached the
   // second stage, so the reset value of the pipe is never mistaken for a
   // released button.
   // ---------------------------------------------------------------------
   logic       syncMeta;
   logic       syncOut;
   logic [1:0] syncValid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         syncMeta  <= 1'b0;
         syncOut   <= 1'b0;
         syncValid <= 2'b00;
      end else begin
         syncMeta  <= btnRaw;
         syncOut   <= syncMeta;
         syncValid <= {syncValid[0], 1'b1};
      end
   end

   // Level presented to the press FSM, plus a flag saying it reflects the
   // real button rather than a reset value.
   logic level;
   logic levelValid;

`ifdef DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_CYCLES);

   logic             sampleReg;
   logic [CNT_W-1:0] stableCnt;
   logic [CNT_W-1:0] stableCntNext;
   logic             acceptedReg;
   logic             acceptedValidReg;

   // stableCnt = number of consecutive identical samples seen so far,
   // saturating at the target. A change (or the first valid sample)
   // restarts the run at 1.
   always_comb begin
      stableCntNext = stableCnt;
      if ((syncOut != sampleReg) || (stableCnt == '0)) begin
         stableCntNext = CNT_W'(1);
      end else if (stableCnt != CNT_TARGET) begin
         stableCntNext = stableCnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sampleReg        <= 1'b0;
         stableCnt        <= '0;
         acceptedReg      <= 1'b0;
         acceptedValidReg <= 1'b0;
      end else if (syncValid[1]) begin
         sampleReg <= syncOut;
         stableCnt <= stableCntNext;
         if (stableCntNext == CNT_TARGET) begin
            acceptedReg      <= syncOut;
            acceptedValidReg <= 1'b1;
         end
      end
   end

   assign level      = acceptedReg;
   assign levelValid = acceptedValidReg;
`else
   assign level      = syncOut;
   assign levelValid = syncValid[1];
`endif

   // ---------------------------------------------------------------------
   // Press FSM. IDLE is only left on a genuine released level, so a button
   // held through reset release never produces a strobe.
   // ---------------------------------------------------------------------
   pressState_t stateReg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateReg <= PRESS_IDLE;
      end else begin
         case (stateReg)
            PRESS_IDLE:    if (levelValid && !level) stateReg <= PRESS_ARMED;
            PRESS_ARMED:   if (levelValid &&  level) stateReg <= PRESS_PRESSED;
            PRESS_PRESSED: if (levelValid && !level) stateReg <= PRESS_ARMED;
            default:       stateReg <= PRESS_IDLE;
         endcase
      end
   end

   // The strobe marks the ARMED->PRESSED transition cycle itself; decoding it
   // from the state register and the accepted level keeps the raw-edge to
   // count-update latency at two synchroniser stages plus the count register.
   assign pressStrobe = (stateReg == PRESS_ARMED) && levelValid && level;

endmodule : btn_conditioner

// File: rtl/btn_down_counter.sv
// -----------------------------------------------------------------------------
// btn_down_counter
//   Modulo-MODULUS down counter advanced by debounced push-button presses.
//   btn_dec decrements (wrapping 0 -> MODULUS-1 with a borrow pulse),
//   btn_load reloads MODULUS-1. Load wins when both strobe together.
//   Build option: define DEBOUNCE_EN to debounce both buttons.
//
// Ports
//   clk       in   1      system clock, rising edge
//   reset     in   1      asynchronous, active-low reset
//   btn_dec   in   1      raw decrement button
//   btn_load  in   1      raw reload button
//   count     out  WIDTH  current count, always within 0..MODULUS-1
//   zero      out  1      high while count == 0
//   borrow    out  1      one-cycle pulse on the 0 -> MODULUS-1 wrap
// -----------------------------------------------------------------------------
module btn_down_counter
   import btn_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int MODULUS         = 10,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_dec,
   input  logic             btn_load,
   output logic [WIDTH-1:0] count,
   output logic             zero,
   output logic             borrow
);

   if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : gBadModulus
      $error("btn_down_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
   end

   localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

   // ---------------------------------------------------------------------
   // One conditioner per button
   // ---------------------------------------------------------------------
   logic [NUM_BUTTONS-1:0] btnRaw;
   logic [NUM_BUTTONS-1:0] btnStrobe;

   assign btnRaw[BTN_DEC]  = btn_dec;
   assign btnRaw[BTN_LOAD] = btn_load;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BUTTONS; gi++) begin : gButton
         btn_conditioner #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) uConditioner (
            .clk         (clk),
            .reset       (reset),
            .btnRaw      (btnRaw[gi]),
            .pressStrobe (btnStrobe[gi])
         );
      end
   endgenerate

   logic decStrobe;
   logic loadStrobe;

   assign decStrobe  = btnStrobe[BTN_DEC];
   assign loadStrobe = btnStrobe[BTN_LOAD];

   // ---------------------------------------------------------------------
   // Count / borrow next-state. The wrap is an explicit compare against 0,
   // so non-power-of-two moduli never rely on natural overflow.
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] countReg;
   logic [WIDTH-1:0] countNext;
   logic             zeroReg;
   logic             borrowReg;
   logic             borrowNext;

   always_comb begin
      countNext  = countReg;
      borrowNext = 1'b0;
      if (loadStrobe) begin
         countNext = MAX_COUNT;
      end else if (decStrobe) begin
         if (countReg == '0) begin
            countNext  = MAX_COUNT;
            borrowNext = 1'b1;
         end else begin
            countNext = countReg - WIDTH'(1);
         end
      end
   end

   // zero is registered from countNext so it moves in the same cycle as count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         countReg  <= '0;
         zeroReg   <= 1'b1;
         borrowReg <= 1'b0;
      end else begin
         countReg  <= countNext;
         zeroReg   <= (countNext == '0);
         borrowReg <= borrowNext;
      end
   end

   assign count  = countReg;
   assign zero   = zeroReg;
   assign borrow = borrowReg;

endmodule : btn_down_counter

// File: tb/tb_btn_down_counter.sv
// -----------------------------------------------------------------------------
// tb_btn_down_counter
//   Directed bench for btn_down_counter (MODULUS=10, WIDTH=4, DEBOUNCE_CYCLES=16).
//   Expected outputs are pushed to a scoreboard queue when a press is driven
//   and popped when the count update is due.
// -----------------------------------------------------------------------------
module tb_btn_down_counter;

   localparam int WIDTH   = 4;
   localparam int MODULUS = 10;
   localparam int DBC     = 16;
`ifdef DEBOUNCE_EN
   localparam int LAT = DBC + 3;
`else
   localparam int LAT = 3;
`endif

   logic             clk;
   logic             reset;
   logic             btn_dec;
   logic             btn_load;
   logic [WIDTH-1:0] count;
   logic             zero;
   logic             borrow;

   btn_down_counter #(
      .WIDTH           (WIDTH),
      .MODULUS         (MODULUS),
      .DEBOUNCE_CYCLES (DBC)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .btn_dec  (btn_dec),
      .btn_load (btn_load),
      .count    (count),
      .zero     (zero),
      .borrow   (borrow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] cnt;
      logic             zro;
      logic             brw;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   modelCount = 0;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, landing 1 time unit after the last one.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one press (dec and/or load), check the update lands exactly LAT
   // edges later, then release and let the conditioner re-arm.
   task automatic press(input bit dec, input bit load, input int hold, input string tag);
      exp_t e;
      exp_t got;
      if (load) begin
         e.cnt = WIDTH'(MODULUS - 1);
         e.brw = 1'b0;
      end else if (modelCount == 0) begin
         e.cnt = WIDTH'(MODULUS - 1);
         e.brw = 1'b1;
      end else begin
         e.cnt = WIDTH'(modelCount - 1);
         e.brw = 1'b0;
      end
      e.zro = (e.cnt == 0);
      sb.push_back(e);
      btn_dec  = dec;
      btn_load = load;
      tick(LAT - 1);
      cmp({tag, " before"}, 32'(count), 32'(modelCount));
      tick(1);
      if (sb.size() == 0) begin
         cmp({tag, " scoreboard"}, 32'(sb.size()), 32'd1);
      end else begin
         got = sb.pop_front();
         $display("press %s: count=%0d zero=%0b borrow=%0b (exp %0d/%0b/%0b)",
                  tag, count, zero, borrow, got.cnt, got.zro, got.brw);
         cmp({tag, " count"}, 32'(count), 32'(got.cnt));
         cmp({tag, " zero"}, 32'(zero), 32'(got.zro));
         cmp({tag, " borrow"}, 32'(borrow), 32'(got.brw));
         modelCount = int'(got.cnt);
      end
      tick(1);
      cmp({tag, " borrow off"}, 32'(borrow), 32'd0);
      tick(hold - LAT - 1);
      cmp({tag, " held"}, 32'(count), 32'(modelCount));
      btn_dec  = 1'b0;
      btn_load = 1'b0;
      tick(40);
      cmp({tag, " released"}, 32'(count), 32'(modelCount));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset    = 1'b0;
      btn_dec  = 1'b1;
      btn_load = 1'b0;

      // 1. reset with btn_dec held, release reset, still held: no strobe
      tick(3);
      cmp("reset count", 32'(count), 32'd0);
      cmp("reset zero", 32'(zero), 32'd1);
      cmp("reset borrow", 32'(borrow), 32'd0);
      reset = 1'b1;
      tick(50);
      cmp("held through reset count", 32'(count), 32'd0);
      cmp("held through reset zero", 32'(zero), 32'd1);
      btn_dec = 1'b0;
      tick(40);
      modelCount = 0;

      // 2. wrap from 0
      press(1'b1, 1'b0, 40, "t2 wrap");

      // 3. ten decrements from 9
      for (int i = 0; i < 10; i++) press(1'b1, 1'b0, 40, $sformatf("t3 dec%0d", i));

      // down to 3, then both buttons together
      for (int i = 0; i < 6; i++) press(1'b1, 1'b0, 40, $sformatf("t4 prep%0d", i));
      cmp("t4 at three", 32'(count), 32'd3);
      press(1'b1, 1'b1, 40, "t4 both");

      // plain load from a mid value
      press(1'b1, 1'b0, 40, "load prep0");
      press(1'b1, 1'b0, 40, "load prep1");
      press(1'b0, 1'b1, 40, "load only");

      // 5. short pulses
`ifdef DEBOUNCE_EN
      for (int i = 0; i < 4; i++) begin
         btn_dec = 1'b1;
         tick(5);
         btn_dec = 1'b0;
         tick(5);
      end
      tick(30);
      cmp("t5 glitches ignored", 32'(count), 32'(modelCount));
      press(1'b1, 1'b0, 20, "t5 debounced");
`else
      press(1'b1, 1'b0, 5, "t5 short pulse");
`endif

      // 6. reach 5, then assert reset mid-hold
      while (modelCount != 5) press(1'b1, 1'b0, 40, "t6 prep");
      btn_dec = 1'b1;
      tick(10);
      #2;
      reset = 1'b0;
      #1;
      cmp("t6 async count", 32'(count), 32'd0);
      cmp("t6 async zero", 32'(zero), 32'd1);
      cmp("t6 async borrow", 32'(borrow), 32'd0);
      tick(2);
      reset = 1'b1;
      modelCount = 0;
      tick(60);
      cmp("t6 held after reset", 32'(count), 32'd0);
      btn_dec = 1'b0;
      tick(40);
      press(1'b1, 1'b0, 40, "t6 recovery");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_btn_down_counter
